// File: rtl/lsu.sv
// rtl/lsu.sv - load/store stage: bus request/response and one-entry writeback register
module lsu #(
  parameter int CPU_WIDTH  = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // upstream (execute) handshake
  input  logic                  alu_mem_valid,
  output logic                  mem_alu_ready,
  input  logic [CPU_WIDTH-1:0]  i_exu_res,
  input  logic [CPU_WIDTH-1:0]  i_rs2,
  input  logic                  i_mem_ren,
  input  logic                  i_mem_wen,
  input  logic [1:0]            i_mem_size,
  input  logic                  i_mem_unsigned,
  input  logic [4:0]            i_rd,
  input  logic                  i_rd_wen,
  // data bus
  output logic                  o_dbus_req_valid,
  input  logic                  i_dbus_req_ready,
  output logic [ADDR_WIDTH-1:0] o_dbus_addr,
  output logic                  o_dbus_wen,
  output logic [CPU_WIDTH-1:0]  o_dbus_wdata,
  output logic [7:0]            o_dbus_wstrb,
  input  logic                  i_dbus_resp_valid,
  input  logic [CPU_WIDTH-1:0]  i_dbus_rdata,
  input  logic                  i_dbus_resp_err,
  // writeback handshake
  output logic                  mem_wb_valid,
  input  logic                  wb_mem_ready,
  output logic [CPU_WIDTH-1:0]  o_wb_data,
  output logic [4:0]            o_rd,
  output logic                  o_rd_wen,
  output logic                  o_mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t               state_q, state_d;

  // latched request fields
  logic [CPU_WIDTH-1:0] addr_q, addr_d;
  logic [CPU_WIDTH-1:0] rs2_q, rs2_d;
  logic                 wen_q, wen_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [4:0]           rd_q, rd_d;
  logic                 rd_wen_q, rd_wen_d;

  // writeback output register
  logic [CPU_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                 wb_rd_wen_q, wb_rd_wen_d;
  logic                 mem_err_q, mem_err_d;

  logic                 in_mem_op;
  logic                 in_misaligned;
  logic                 req_active;
  logic                 store_active;
  logic [7:0]           size_mask;
  logic [5:0]           lane_shift;
  logic [CPU_WIDTH-1:0] load_shifted;
  logic [CPU_WIDTH-1:0] load_ext;

  assign in_mem_op    = i_mem_ren | i_mem_wen;
  assign req_active   = (state_q == S_REQ);
  assign store_active = req_active & wen_q;
  assign lane_shift   = {addr_q[2:0], 3'b000};
  assign load_shifted = i_dbus_rdata >> lane_shift;

  // natural-alignment check of the incoming address against the access size
  always_comb begin
    in_misaligned = 1'b0;
    case (i_mem_size)
      2'd1:    in_misaligned = i_exu_res[0];
      2'd2:    in_misaligned = |i_exu_res[1:0];
      2'd3:    in_misaligned = |i_exu_res[2:0];
      default: in_misaligned = 1'b0;
    endcase
  end

  // byte-lane mask for the latched access size, before shifting into position
  always_comb begin
    size_mask = 8'h00;
    case (size_q)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // truncate the lane-aligned read data to the access size and extend to 64 bits
  always_comb begin
    load_ext = load_shifted;
    case (size_q)
      2'd0: load_ext = uns_q ? {56'd0, load_shifted[7:0]}
                             : {{56{load_shifted[7]}}, load_shifted[7:0]};
      2'd1: load_ext = uns_q ? {48'd0, load_shifted[15:0]}
                             : {{48{load_shifted[15]}}, load_shifted[15:0]};
      2'd2: load_ext = uns_q ? {32'd0, load_shifted[31:0]}
                             : {{32{load_shifted[31]}}, load_shifted[31:0]};
      default: load_ext = load_shifted;
    endcase
  end

  // handshake and bus outputs; bus fields are forced to zero outside REQ
  assign mem_alu_ready    = (state_q == S_IDLE) || ((state_q == S_OUT) && wb_mem_ready);
  assign o_dbus_req_valid = req_active;
  assign o_dbus_addr      = req_active ? {addr_q[ADDR_WIDTH-1:3], 3'b000} : '0;
  assign o_dbus_wen       = store_active;
  assign o_dbus_wdata     = store_active ? (rs2_q << lane_shift) : '0;
  assign o_dbus_wstrb     = store_active ? (size_mask << addr_q[2:0]) : 8'h00;
  assign mem_wb_valid     = (state_q == S_OUT);
  assign o_wb_data        = wb_data_q;
  assign o_rd             = rd_q;
  assign o_rd_wen         = wb_rd_wen_q;
  assign o_mem_err        = mem_err_q;

  // next-state and register-update logic for the four-state access sequence
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rs2_d       = rs2_q;
    wen_d       = wen_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rd_d        = rd_q;
    rd_wen_d    = rd_wen_q;
    wb_data_d   = wb_data_q;
    wb_rd_wen_d = wb_rd_wen_q;
    mem_err_d   = mem_err_q;
    case (state_q)
      S_IDLE, S_OUT: begin
        if (mem_alu_ready) begin
          if (alu_mem_valid) begin
            addr_d   = i_exu_res;
            rs2_d    = i_rs2;
            wen_d    = i_mem_wen;
            size_d   = i_mem_size;
            uns_d    = i_mem_unsigned;
            rd_d     = i_rd;
            rd_wen_d = i_rd_wen;
            if (!in_mem_op) begin
              state_d     = S_OUT;
              wb_data_d   = i_exu_res;
              wb_rd_wen_d = i_rd_wen;
              mem_err_d   = 1'b0;
            end else if (in_misaligned) begin
              // misaligned accesses never reach the bus; report the faulting address
              state_d     = S_OUT;
              wb_data_d   = i_exu_res;
              wb_rd_wen_d = 1'b0;
              mem_err_d   = 1'b1;
            end else begin
              state_d = S_REQ;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_REQ: begin
        if (i_dbus_req_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (i_dbus_resp_valid) begin
          state_d = S_OUT;
          if (i_dbus_resp_err) begin
            // bus faults also report the faulting address
            wb_data_d   = addr_q;
            wb_rd_wen_d = 1'b0;
            mem_err_d   = 1'b1;
          end else if (wen_q) begin
            wb_data_d   = '0;
            wb_rd_wen_d = 1'b0;
            mem_err_d   = 1'b0;
          end else begin
            wb_data_d   = load_ext;
            wb_rd_wen_d = rd_wen_q;
            mem_err_d   = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rs2_q       <= '0;
      wen_q       <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      rd_q        <= 5'd0;
      rd_wen_q    <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_wen_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rs2_q       <= rs2_d;
      wen_q       <= wen_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rd_q        <= rd_d;
      rd_wen_q    <= rd_wen_d;
      wb_data_q   <= wb_data_d;
      wb_rd_wen_q <= wb_rd_wen_d;
      mem_err_q   <= mem_err_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed and randomized checks of lsu against a transaction-level model
module tb_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        alu_mem_valid;
  logic        mem_alu_ready;
  logic [63:0] i_exu_res;
  logic [63:0] i_rs2;
  logic        i_mem_ren;
  logic        i_mem_wen;
  logic [1:0]  i_mem_size;
  logic        i_mem_unsigned;
  logic [4:0]  i_rd;
  logic        i_rd_wen;
  logic        o_dbus_req_valid;
  logic        i_dbus_req_ready;
  logic [63:0] o_dbus_addr;
  logic        o_dbus_wen;
  logic [63:0] o_dbus_wdata;
  logic [7:0]  o_dbus_wstrb;
  logic        i_dbus_resp_valid;
  logic [63:0] i_dbus_rdata;
  logic        i_dbus_resp_err;
  logic        mem_wb_valid;
  logic        wb_mem_ready;
  logic [63:0] o_wb_data;
  logic [4:0]  o_rd;
  logic        o_rd_wen;
  logic        o_mem_err;

  lsu dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .alu_mem_valid     (alu_mem_valid),
    .mem_alu_ready     (mem_alu_ready),
    .i_exu_res         (i_exu_res),
    .i_rs2             (i_rs2),
    .i_mem_ren         (i_mem_ren),
    .i_mem_wen         (i_mem_wen),
    .i_mem_size        (i_mem_size),
    .i_mem_unsigned    (i_mem_unsigned),
    .i_rd              (i_rd),
    .i_rd_wen          (i_rd_wen),
    .o_dbus_req_valid  (o_dbus_req_valid),
    .i_dbus_req_ready  (i_dbus_req_ready),
    .o_dbus_addr       (o_dbus_addr),
    .o_dbus_wen        (o_dbus_wen),
    .o_dbus_wdata      (o_dbus_wdata),
    .o_dbus_wstrb      (o_dbus_wstrb),
    .i_dbus_resp_valid (i_dbus_resp_valid),
    .i_dbus_rdata      (i_dbus_rdata),
    .i_dbus_resp_err   (i_dbus_resp_err),
    .mem_wb_valid      (mem_wb_valid),
    .wb_mem_ready      (wb_mem_ready),
    .o_wb_data         (o_wb_data),
    .o_rd              (o_rd),
    .o_rd_wen          (o_rd_wen),
    .o_mem_err         (o_mem_err)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_op(input logic [63:0] exu, input logic [63:0] rs2, input logic ren,
                          input logic wen, input logic [1:0] size, input logic uns,
                          input logic [4:0] rd, input logic rdw);
    alu_mem_valid  = 1'b1;
    i_exu_res      = exu;
    i_rs2          = rs2;
    i_mem_ren      = ren;
    i_mem_wen      = wen;
    i_mem_size     = size;
    i_mem_unsigned = uns;
    i_rd           = rd;
    i_rd_wen       = rdw;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wb_valid"}, mem_wb_valid, 0);
    check({tag, "_req_valid"}, o_dbus_req_valid, 0);
    check({tag, "_wb_data"}, o_wb_data, 0);
    check({tag, "_rd"}, o_rd, 0);
    check({tag, "_rd_wen"}, o_rd_wen, 0);
    check({tag, "_err"}, o_mem_err, 0);
    check({tag, "_addr"}, o_dbus_addr, 0);
    check({tag, "_wstrb"}, o_dbus_wstrb, 0);
    check({tag, "_ready"}, mem_alu_ready, 1);
  endtask

  // one aligned bus transaction with optional request and writeback stalls
  task automatic mem_txn(input string tag, input logic [63:0] addr, input logic [63:0] rs2,
                         input logic wen, input logic [1:0] size, input logic uns,
                         input logic [63:0] rdata, input logic err,
                         input int req_hold, input int wb_hold,
                         input logic [63:0] e_addr, input logic [7:0] e_strb,
                         input logic [63:0] e_wdata, input logic [63:0] e_data,
                         input logic e_rdwen, input logic e_err);
    wb_mem_ready     = 1'b1;
    i_dbus_req_ready = 1'b0;
    drive_op(addr, rs2, !wen, wen, size, uns, 5'd9, 1'b1);
    cyc();
    alu_mem_valid = 1'b0;
    for (int k = 0; k <= req_hold; k++) begin
      check({tag, "_req_valid"}, o_dbus_req_valid, 1);
      check({tag, "_req_addr"}, o_dbus_addr, e_addr);
      check({tag, "_req_wen"}, o_dbus_wen, wen);
      check({tag, "_req_wstrb"}, o_dbus_wstrb, e_strb);
      check({tag, "_req_wdata"}, o_dbus_wdata, e_wdata);
      check({tag, "_req_ready_up"}, mem_alu_ready, 0);
      if (k == req_hold) i_dbus_req_ready = 1'b1;
      cyc();
    end
    i_dbus_req_ready = 1'b0;
    check({tag, "_resp_no_req"}, o_dbus_req_valid, 0);
    check({tag, "_resp_no_wb"}, mem_wb_valid, 0);
    i_dbus_resp_valid = 1'b1;
    i_dbus_rdata      = rdata;
    i_dbus_resp_err   = err;
    cyc();
    i_dbus_resp_valid = 1'b0;
    i_dbus_rdata      = '0;
    i_dbus_resp_err   = 1'b0;
    check({tag, "_wb_valid"}, mem_wb_valid, 1);
    check({tag, "_wb_data"}, o_wb_data, e_data);
    check({tag, "_wb_rd"}, o_rd, 9);
    check({tag, "_wb_rd_wen"}, o_rd_wen, e_rdwen);
    check({tag, "_wb_err"}, o_mem_err, e_err);
    wb_mem_ready = 1'b0;
    for (int k = 0; k < wb_hold; k++) begin
      cyc();
      check({tag, "_hold_valid"}, mem_wb_valid, 1);
      check({tag, "_hold_data"}, o_wb_data, e_data);
      check({tag, "_hold_ready_up"}, mem_alu_ready, 0);
    end
    wb_mem_ready = 1'b1;
    cyc();
    check({tag, "_done_valid"}, mem_wb_valid, 0);
  endtask

  // ---------------- randomized reference model ----------------
  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        rdw;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [63:0] addr;
    logic        wen;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
  } req_t;

  exp_t        exp_q[$];
  req_t        req_q[$];
  logic [63:0] ref_mem[bit [63:0]];
  logic [63:0] slv_mem[bit [63:0]];

  bit          drv_busy;
  bit          rsp_pend;
  int          rsp_dly;
  logic [63:0] rsp_data;
  logic        rsp_err;

  function automatic logic [63:0] init_dw(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0] ^ 32'h0F0F_00FF};
  endfunction

  function automatic bit err_region(input logic [63:0] a);
    return a[63:60] == 4'hF;
  endfunction

  // expected result and bus request for the op currently on the upstream port
  task automatic model_accept();
    int          n;
    int          o;
    logic [63:0] a;
    logic [63:0] dwa;
    logic [63:0] dw;
    logic [63:0] v;
    req_t        r;
    a   = i_exu_res;
    n   = 1 << i_mem_size;
    o   = int'(a % 64'd8);
    dwa = a - 64'(o);
    if (!i_mem_ren && !i_mem_wen) begin
      exp_q.push_back('{i_exu_res, i_rd, i_rd_wen, 1'b0});
    end else if ((a % 64'(n)) != 0) begin
      exp_q.push_back('{a, i_rd, 1'b0, 1'b1});
    end else begin
      r.addr  = dwa;
      r.wen   = i_mem_wen;
      r.wstrb = i_mem_wen ? 8'(((1 << n) - 1) << o) : 8'h00;
      r.wdata = i_mem_wen ? (i_rs2 << (8 * o)) : 64'd0;
      req_q.push_back(r);
      dw = ref_mem.exists(dwa) ? ref_mem[dwa] : init_dw(dwa);
      if (err_region(a)) begin
        exp_q.push_back('{a, i_rd, 1'b0, 1'b1});
      end else if (i_mem_wen) begin
        for (int i = 0; i < n; i++) dw[8*(o+i) +: 8] = i_rs2[8*i +: 8];
        ref_mem[dwa] = dw;
        exp_q.push_back('{64'd0, i_rd, 1'b0, 1'b0});
      end else begin
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = dw[8*(o+i) +: 8];
        if (!i_mem_unsigned && n < 8 && v[8*n-1])
          for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
        exp_q.push_back('{v, i_rd, i_rd_wen, 1'b0});
      end
    end
  endtask

  task automatic gen_op();
    int          kind;
    logic [1:0]  size;
    logic [63:0] base;
    logic [63:0] off;
    kind = $urandom_range(0, 2);
    size = 2'($urandom_range(0, 3));
    base = ($urandom_range(0, 7) == 0) ? 64'hF000_0000_0000_1000 : 64'h0000_0000_0000_1000;
    off  = 64'($urandom_range(0, 7) * 8);
    if ($urandom_range(0, 4) == 0) off = off + 64'($urandom_range(0, 7));
    else off = off + 64'((($urandom_range(0, 7)) >> size) << size);
    if (kind == 0)
      drive_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, size,
               1'($urandom), 5'($urandom), 1'($urandom));
    else
      drive_op(base + off, {$urandom, $urandom}, kind == 1, kind == 2, size,
               1'($urandom), 5'($urandom), 1'($urandom));
  endtask

  task automatic run_random(input int ncyc, input bit allow_new);
    int          stall;
    req_t        r;
    exp_t        e;
    logic [63:0] d;
    stall = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge i_clk);
      #1;
      if (!drv_busy) begin
        if (allow_new && $urandom_range(0, 3) != 0) begin
          gen_op();
          drv_busy = 1'b1;
        end else begin
          alu_mem_valid = 1'b0;
        end
      end
      wb_mem_ready      = ($urandom_range(0, 3) != 0);
      i_dbus_req_ready  = ($urandom_range(0, 2) != 0);
      i_dbus_resp_valid = 1'b0;
      i_dbus_resp_err   = 1'b0;
      i_dbus_rdata      = {$urandom, $urandom};
      if (rsp_pend) begin
        rsp_dly--;
        if (rsp_dly == 0) begin
          i_dbus_resp_valid = 1'b1;
          i_dbus_rdata      = rsp_data;
          i_dbus_resp_err   = rsp_err;
        end
      end
      @(negedge i_clk);
      if (mem_wb_valid && wb_mem_ready) begin
        stall = 0;
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_wb", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_wb_data", o_wb_data, e.data);
          check("rnd_wb_rd", o_rd, e.rd);
          check("rnd_wb_rd_wen", o_rd_wen, e.rdw);
          check("rnd_wb_err", o_mem_err, e.err);
        end
      end
      if (alu_mem_valid && mem_alu_ready) begin
        model_accept();
        drv_busy = 1'b0;
      end
      if (o_dbus_req_valid) begin
        if (req_q.size() == 0) begin
          check("rnd_unexpected_req", 1, 0);
        end else begin
          r = req_q[0];
          check("rnd_req_addr", o_dbus_addr, r.addr);
          check("rnd_req_wen", o_dbus_wen, r.wen);
          check("rnd_req_wstrb", o_dbus_wstrb, r.wstrb);
          check("rnd_req_wdata", o_dbus_wdata, r.wdata);
          if (i_dbus_req_ready) begin
            void'(req_q.pop_front());
            d        = slv_mem.exists(o_dbus_addr) ? slv_mem[o_dbus_addr] : init_dw(o_dbus_addr);
            rsp_err  = err_region(o_dbus_addr);
            rsp_data = d;
            if (o_dbus_wen && !rsp_err) begin
              for (int b = 0; b < 8; b++)
                if (o_dbus_wstrb[b]) d[8*b +: 8] = o_dbus_wdata[8*b +: 8];
              slv_mem[o_dbus_addr] = d;
            end
            rsp_pend = 1'b1;
            rsp_dly  = $urandom_range(1, 3);
          end
        end
      end
      if (i_dbus_resp_valid) rsp_pend = 1'b0;
      if (exp_q.size() != 0 || drv_busy) stall++;
      if (stall > 200) begin
        check("rnd_timeout", 1, 0);
        break;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    i_rst_n           = 1'b0;
    alu_mem_valid     = 1'b0;
    i_exu_res         = '0;
    i_rs2             = '0;
    i_mem_ren         = 1'b0;
    i_mem_wen         = 1'b0;
    i_mem_size        = 2'd0;
    i_mem_unsigned    = 1'b0;
    i_rd              = 5'd0;
    i_rd_wen          = 1'b0;
    i_dbus_req_ready  = 1'b0;
    i_dbus_resp_valid = 1'b0;
    i_dbus_rdata      = '0;
    i_dbus_resp_err   = 1'b0;
    wb_mem_ready      = 1'b0;
    drv_busy          = 1'b0;
    rsp_pend          = 1'b0;
    rsp_dly           = 0;
    rsp_data          = '0;
    rsp_err           = 1'b0;
    cyc();
    cyc();
    check_idle_outputs("reset");
    i_rst_n = 1'b1;

    // pass-through, back-to-back with writeback always ready
    wb_mem_ready = 1'b1;
    drive_op(64'h1234, 64'd0, 1'b0, 1'b0, 2'd3, 1'b0, 5'd5, 1'b1);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      check("pass_valid", mem_wb_valid, 1);
      check("pass_data", o_wb_data, 64'h1234 + 64'(i - 1) * 64'h111);
      check("pass_rd", o_rd, 64'(5 + i - 1));
      check("pass_err", o_mem_err, 0);
      check("pass_ready", mem_alu_ready, 1);
      drive_op(64'h1234 + 64'(i) * 64'h111, 64'd0, 1'b0, 1'b0, 2'd3, 1'b0, 5'(5 + i), 1'b1);
      cyc();
    end
    check("pass_last_data", o_wb_data, 64'h1678);
    alu_mem_valid = 1'b0;
    cyc();
    check("pass_drain", mem_wb_valid, 0);

    mem_txn("lb", 64'h8000_0003, 64'd0, 1'b0, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 1'b0, 0, 0,
            64'h8000_0000, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0);
    mem_txn("lbu", 64'h8000_0003, 64'd0, 1'b0, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 1'b0, 0, 0,
            64'h8000_0000, 8'h00, 64'd0, 64'h80, 1'b1, 1'b0);
    mem_txn("sw", 64'h100C, 64'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 64'd0, 1'b0, 4, 3,
            64'h1008, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'd0, 1'b0, 1'b0);
    mem_txn("lh_neg", 64'h2006, 64'd0, 1'b0, 2'd1, 1'b0, 64'h8001_0000_0000_0000, 1'b0, 1, 1,
            64'h2000, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0);
    mem_txn("ld_buserr", 64'h2000, 64'd0, 1'b0, 2'd3, 1'b0, 64'h1, 1'b1, 0, 0,
            64'h2000, 8'h00, 64'd0, 64'h2000, 1'b0, 1'b1);

    // misaligned half load: no bus request, error reported directly
    drive_op(64'h1001, 64'd0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd3, 1'b1);
    cyc();
    alu_mem_valid = 1'b0;
    check("mis_req_valid", o_dbus_req_valid, 0);
    check("mis_wb_valid", mem_wb_valid, 1);
    check("mis_err", o_mem_err, 1);
    check("mis_rd_wen", o_rd_wen, 0);
    check("mis_data", o_wb_data, 64'h1001);
    cyc();
    check("mis_drain", mem_wb_valid, 0);

    // reset while waiting for the response; a late response must be ignored
    i_dbus_req_ready = 1'b1;
    drive_op(64'h3000, 64'd0, 1'b1, 1'b0, 2'd3, 1'b0, 5'd4, 1'b1);
    cyc();
    alu_mem_valid = 1'b0;
    cyc();
    i_dbus_req_ready = 1'b0;
    check("rst_in_resp_noreq", o_dbus_req_valid, 0);
    i_rst_n = 1'b0;
    cyc();
    check_idle_outputs("rst_mid");
    i_rst_n           = 1'b1;
    i_dbus_resp_valid = 1'b1;
    i_dbus_rdata      = 64'h1234_5678;
    cyc();
    i_dbus_resp_valid = 1'b0;
    check("late_resp_wb_valid", mem_wb_valid, 0);
    cyc();
    check("late_resp_wb_valid2", mem_wb_valid, 0);

    // randomized traffic against the model, then drain
    run_random(3000, 1'b1);
    run_random(300, 1'b0);
    check("rnd_exp_empty", 64'(exp_q.size()), 0);
    check("rnd_req_empty", 64'(req_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Memory-access stage directly downstream of the execute stage. It consumes the ALU result (address or pass-through value) and store data over a valid/ready handshake.
- Loads and stores issue one transaction on a simple request/response data bus. Load data is aligned and extended to 64 bits.
- The result goes to writeback through a one-entry output register with its own valid/ready handshake.

Parameters:
- CPU_WIDTH, 64, datapath width; fixed at 64 for this block.
- ADDR_WIDTH, 64, data-bus address width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- alu_mem_valid  in  1  upstream transaction valid.
- mem_alu_ready  out  1  this stage accepts an upstream transaction.
- i_exu_res  in  64  ALU result; address for loads/stores, writeback value otherwise.
- i_rs2  in  64  store data.
- i_mem_ren  in  1  load.
- i_mem_wen  in  1  store. i_mem_ren and i_mem_wen are never both 1.
- i_mem_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- i_mem_unsigned  in  1  zero-extend the load (LBU/LHU/LWU).
- i_rd  in  5  destination register index.
- i_rd_wen  in  1  destination register write enable.
- o_dbus_req_valid  out  1  bus request valid.
- i_dbus_req_ready  in  1  bus accepts the request.
- o_dbus_addr  out  64  request address, aligned down to 8 bytes.
- o_dbus_wen  out  1  1 = write.
- o_dbus_wdata  out  64  write data, shifted into byte lanes.
- o_dbus_wstrb  out  8  byte-lane strobes.
- i_dbus_resp_valid  in  1  response valid; always accepted.
- i_dbus_rdata  in  64  read data for the aligned dword.
- i_dbus_resp_err  in  1  bus error on this response.
- mem_wb_valid  out  1  output register valid.
- wb_mem_ready  in  1  writeback accepts the output.
- o_wb_data  out  64  writeback value.
- o_rd  out  5  destination register index.
- o_rd_wen  out  1  destination register write enable.
- o_mem_err  out  1  exception flag: misaligned access or bus error.

Behaviour:
- States: IDLE, REQ, RESP, OUT.
- Reset (i_rst_n=0 at a rising edge): state=IDLE, all outputs 0, request fields cleared.
- Reset mid-transaction abandons it. Any later response arriving in IDLE is ignored.
- mem_alu_ready = (state==IDLE) or (state==OUT and wb_mem_ready).
- Accept = alu_mem_valid and mem_alu_ready. On accept, latch all inputs.
- Non-memory op: next state OUT. Latency 1 cycle: mem_wb_valid=1 the cycle after accept, o_wb_data=i_exu_res, o_mem_err=0.
- Misaligned memory op (half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0):
  - No bus request is issued; next state OUT.
  - o_mem_err=1, o_rd_wen=0, o_wb_data=address.
- Aligned memory op: next state REQ.
- REQ: o_dbus_req_valid=1. Address, wen, wdata and wstrb are held stable until i_dbus_req_ready=1, then go to RESP.
  - o_dbus_addr = {addr[63:3],3'b0}.
  - o_dbus_wdata = rs2 << (addr[2:0]*8).
  - o_dbus_wstrb = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
  - Loads drive wstrb=0 and wdata=0.
- RESP: wait for i_dbus_resp_valid. Stores also receive a response. A response in the same cycle as req_ready is not allowed by the bus; it can arrive earliest the next cycle.
- On response, load result = (rdata >> addr[2:0]*8), truncated to size, then sign- or zero-extended to 64 bits. Store result: o_wb_data=0, o_rd_wen=0.
- Bus error on the response: o_mem_err=1, o_rd_wen=0. Then go to OUT.
- OUT: mem_wb_valid=1 and all outputs held until wb_mem_ready.
  - On handshake with a simultaneous new accept: reload directly. A non-memory or misaligned op stays in OUT with the new data; an aligned memory op goes to REQ.
  - On handshake with no new accept: go to IDLE, mem_wb_valid=0.
- Throughput: one non-memory op per cycle with wb_mem_ready held at 1.
- Memory op minimum latency, accept to mem_wb_valid: 3 cycles (REQ 1, RESP 1, OUT).

Test Plan:
- Pass-through: an ADD result of 0x1234 with rd=5, then back-to-back ops, with wb_mem_ready=1 -> mem_wb_valid the next cycle, o_wb_data=0x1234, o_rd=5, one op per cycle with no bubbles.
- Signed byte load, addr=0x80000003, rdata=0x00000000_80000000 -> o_dbus_addr=0x80000000, wstrb=0; byte = 0x80 -> o_wb_data=0xFFFFFFFFFFFFFF80. The same access with the unsigned flag -> 0x80.
- Word store, addr=0x100C, rs2=0xDEADBEEF -> wstrb=0xF0, wdata=0xDEADBEEF_00000000. o_rd_wen=0 after the response.
- Backpressure:
  - i_dbus_req_ready held at 0 for 4 cycles -> request fields stable throughout, mem_alu_ready=0.
  - wb_mem_ready=0 for 3 cycles -> output stable, mem_alu_ready=0.
- Misaligned half-word load at addr=0x1001 -> no o_dbus_req_valid, o_mem_err=1, o_rd_wen=0, o_wb_data=0x1001. A bus response with i_dbus_resp_err=1 -> o_mem_err=1.
- Reset asserted while in RESP -> the next cycle has all outputs 0 and state IDLE. A late i_dbus_resp_valid is ignored and does not produce mem_wb_valid.
